uart_cmd_ctrl: RTL

Command stage between uart_receiver and the pixel/colour datapath, with a return path to uart_transmitter.
- Decodes received ASCII bytes into circle-position and colour updates.
- Clamps the circle position to keep it fully on screen.
- Commits updates to the display only at frame boundaries, so there is no tearing.
- Queues echo bytes in a small FIFO and drains them to the transmitter with an idle/transmit handshake.

---
 rtl/uart_cmd_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// uart_cmd_ctrl: decodes UART bytes into clamped circle/colour updates that are
// committed at frame end, and echoes accepted commands back through a FIFO.
// Revision: 1.0
// ============================================================================
module uart_cmd_ctrl #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int RADIUS     = 100,
    parameter int STEP       = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_receive,
    input  logic        end_of_frame,
    input  logic        tx_idle,
    output logic [7:0]  tx_data,
    output logic        tx_transmit,
    output logic [15:0] circle_x,
    output logic [15:0] circle_y,
    output logic [11:0] color,
    output logic        drop_flag
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [16:0] X_MIN = 17'(RADIUS);
    localparam logic signed [16:0] X_MAX = 17'(WIDTH - 1 - RADIUS);
    localparam logic signed [16:0] Y_MIN = 17'(RADIUS);
    localparam logic signed [16:0] Y_MAX = 17'(HEIGHT - 1 - RADIUS);
    localparam logic signed [16:0] STEP_S = 17'(STEP);
    localparam logic [15:0] X_INIT = 16'(WIDTH / 2);
    localparam logic [15:0] Y_INIT = 16'(HEIGHT / 2);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SEND      = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [15:0]        pend_x, pend_y;
    logic [11:0]        pend_col;
    logic               cmd_ok, set_col;
    logic [7:0]         echo;
    logic [11:0]        new_col;
    logic signed [16:0] dx, dy, sum_x, sum_y, next_x, next_y;

    always_comb begin
        cmd_ok  = 1'b1;
        set_col = 1'b0;
        echo    = 8'h00;
        new_col = 12'hfff;
        dx      = '0;
        dy      = '0;
        case (rx_data)
            8'h77:   begin dy = -STEP_S; echo = 8'h57; end
            8'h73:   begin dy =  STEP_S; echo = 8'h53; end
            8'h61:   begin dx = -STEP_S; echo = 8'h41; end
            8'h64:   begin dx =  STEP_S; echo = 8'h44; end
            8'h63:   begin set_col = 1'b1; new_col = 12'h0ff; echo = 8'h43; end
            8'h6d:   begin set_col = 1'b1; new_col = 12'hf0f; echo = 8'h4d; end
            8'h79:   begin set_col = 1'b1; new_col = 12'hff0; echo = 8'h59; end
            8'h20:   begin set_col = 1'b1; new_col = 12'hfff; echo = 8'h5a; end
            default: cmd_ok = 1'b0;
        endcase
    end

    // Signed 17-bit sum so that a step below zero saturates instead of wrapping.
    always_comb begin
        sum_x  = $signed({1'b0, pend_x}) + dx;
        sum_y  = $signed({1'b0, pend_y}) + dy;
        next_x = (sum_x < X_MIN) ? X_MIN : (sum_x > X_MAX) ? X_MAX : sum_x;
        next_y = (sum_y < Y_MIN) ? Y_MIN : (sum_y > Y_MAX) ? Y_MAX : sum_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_x   <= X_INIT;
            pend_y   <= Y_INIT;
            pend_col <= 12'hfff;
            circle_x <= X_INIT;
            circle_y <= Y_INIT;
            color    <= 12'hfff;
        end else begin
            if (rx_receive && cmd_ok) begin
                pend_x <= next_x[15:0];
                pend_y <= next_y[15:0];
                if (set_col) pend_col <= new_col;
            end
            if (end_of_frame) begin
                circle_x <= pend_x;
                circle_y <= pend_y;
                color    <= pend_col;
            end
        end
    end

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop;
    logic [1:0]  state, state_nxt;
    logic [3:0]  busy_cnt;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = rx_receive && cmd_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            drop_flag <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            if (push && (!fifo_full || pop)) begin
                fifo_mem[wr_ptr[AW-1:0]] <= echo;
                wr_ptr <= wr_ptr + 1'b1;
            end else if (push) begin
                drop_flag <= 1'b1;
            end
            if (pop) begin
                tx_data <= fifo_mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy_cnt <= '0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= (state == S_WAIT_BUSY) ? busy_cnt + 1'b1 : 4'd0;
        end
    end

    // A transmitter that never reports busy is assumed to have sent the byte.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (!fifo_empty && tx_idle) state_nxt = S_SEND;
            S_SEND:      state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!tx_idle) state_nxt = S_WAIT_DONE;
                         else if (busy_cnt == 4'd15) state_nxt = S_IDLE;
            S_WAIT_DONE: if (tx_idle) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_transmit = (state == S_SEND);
        pop         = (state == S_IDLE) && !fifo_empty && tx_idle;
    end

endmodule
`default_nettype wire
